// File: rtl/acc_array.sv
// acc_array: LANES independent signed windowed accumulators behind a valid/ready handshake.
// Define ACC_ARRAY_SAT_EN to saturate each lane and flag overflow; the default build wraps.
module acc_array #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int WIDTH     = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CNT_WIDTH-1:0]      len,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [LANES*IN_WIDTH-1:0] i_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [LANES*WIDTH-1:0]    o_data,
  output logic [LANES-1:0]          o_ovf
);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                        state_r;
  logic [LANES-1:0][WIDTH-1:0]   acc_r;
  logic [CNT_WIDTH-1:0]          cnt_r;
  logic [CNT_WIDTH-1:0]          len_r;
  logic [LANES-1:0]              ovf_r;
  logic                          i_ready_r;
  logic                          o_valid_r;

  logic [LANES-1:0][WIDTH-1:0]   next_s;
  logic [LANES-1:0]              ovf_s;
  logic [CNT_WIDTH-1:0]          len_eff_s;
  logic                          transfer_s;
  logic                          first_s;
  logic                          last_s;

`ifdef ACC_ARRAY_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [LANES-1:0][WIDTH:0]     wide_s;

  // Clamp a WIDTH+1 bit signed sum into the signed WIDTH range.
  function automatic logic [WIDTH-1:0] sat_trunc(input logic [WIDTH:0] w);
    logic [WIDTH-1:0] r;
    if (w[WIDTH] != w[WIDTH-1]) begin
      r = w[WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      r = w[WIDTH-1:0];
    end
    return r;
  endfunction

  // Per-lane sum one bit wider than the accumulator so overflow is visible.
  always_comb begin
    wide_s = '0;
    next_s = '0;
    ovf_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      wide_s[i] = {acc_r[i][WIDTH-1], acc_r[i]}
                + (WIDTH+1)'($signed(i_data[i*IN_WIDTH +: IN_WIDTH]));
      next_s[i] = sat_trunc(wide_s[i]);
      ovf_s[i]  = wide_s[i][WIDTH] ^ wide_s[i][WIDTH-1];
    end
  end
`else
  // Per-lane modulo-2^WIDTH sum; overflow is never reported in this build.
  always_comb begin
    next_s = '0;
    ovf_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      next_s[i] = acc_r[i] + WIDTH'($signed(i_data[i*IN_WIDTH +: IN_WIDTH]));
    end
  end
`endif

  // The first beat of a window uses the live len, later beats the latched copy.
  always_comb begin
    transfer_s = i_valid & i_ready_r & (state_r == ST_ACC);
    first_s    = (cnt_r == {CNT_WIDTH{1'b0}});
    len_eff_s  = first_s ? len : len_r;
    last_s     = (cnt_r == len_eff_s);
  end

  // Window state, accumulators and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ACC;
      acc_r     <= '0;
      cnt_r     <= {CNT_WIDTH{1'b0}};
      len_r     <= {CNT_WIDTH{1'b0}};
      ovf_r     <= {LANES{1'b0}};
      i_ready_r <= 1'b0;
      o_valid_r <= 1'b0;
    end else if (clr) begin
      state_r   <= ST_ACC;
      acc_r     <= '0;
      cnt_r     <= {CNT_WIDTH{1'b0}};
      ovf_r     <= {LANES{1'b0}};
      i_ready_r <= 1'b1;
      o_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (transfer_s) begin
            acc_r <= next_s;
            ovf_r <= ovf_r | ovf_s;
            if (first_s) begin
              len_r <= len;
            end else begin
              len_r <= len_r;
            end
            if (last_s) begin
              state_r   <= ST_HOLD;
              i_ready_r <= 1'b0;
              o_valid_r <= 1'b1;
            end else begin
              cnt_r     <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              i_ready_r <= 1'b1;
            end
          end else begin
            i_ready_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (o_ready) begin
            state_r   <= ST_ACC;
            acc_r     <= '0;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            ovf_r     <= {LANES{1'b0}};
            i_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
          end else begin
            o_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_ACC;
          acc_r     <= '0;
          cnt_r     <= {CNT_WIDTH{1'b0}};
          ovf_r     <= {LANES{1'b0}};
          i_ready_r <= 1'b1;
          o_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = i_ready_r;
  assign o_valid = o_valid_r;
  assign o_data  = acc_r;
  assign o_ovf   = ovf_r;

endmodule
